// File: rtl/sspm_connector_v2_if.sv
// Core-side OCP signals and arbiter-side connector signals of one SSPM connector.
// The connector itself uses the slave modport; whatever drives it uses master.
interface sspm_connector_v2_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                      io_superMode;
    logic [2:0]                io_ocp_M_Cmd;
    logic [31:0]               io_ocp_M_Addr;
    logic [DATA_WIDTH-1:0]     io_ocp_M_Data;
    logic [DATA_WIDTH/8-1:0]   io_ocp_M_ByteEn;
    logic [1:0]                io_ocp_S_Resp;
    logic [DATA_WIDTH-1:0]     io_ocp_S_Data;
    logic                      io_connectorSignals_req;
    logic                      io_connectorSignals_select;
    logic [DATA_WIDTH-1:0]     io_connectorSignals_data_in;
    logic [DATA_WIDTH-1:0]     io_connectorSignals_data_out;
    logic [ADDR_WIDTH-1:0]     io_connectorSignals_addr;
    logic [DATA_WIDTH/8-1:0]   io_connectorSignals_byteEn;
    logic                      io_connectorSignals_we;
    logic                      io_connectorSignals_re;

    modport slave (
        input  io_superMode, io_ocp_M_Cmd, io_ocp_M_Addr, io_ocp_M_Data, io_ocp_M_ByteEn,
        input  io_connectorSignals_select, io_connectorSignals_data_in,
        output io_ocp_S_Resp, io_ocp_S_Data,
        output io_connectorSignals_req, io_connectorSignals_data_out, io_connectorSignals_addr,
        output io_connectorSignals_byteEn, io_connectorSignals_we, io_connectorSignals_re
    );

    modport master (
        output io_superMode, io_ocp_M_Cmd, io_ocp_M_Addr, io_ocp_M_Data, io_ocp_M_ByteEn,
        output io_connectorSignals_select, io_connectorSignals_data_in,
        input  io_ocp_S_Resp, io_ocp_S_Data,
        input  io_connectorSignals_req, io_connectorSignals_data_out, io_connectorSignals_addr,
        input  io_connectorSignals_byteEn, io_connectorSignals_we, io_connectorSignals_re
    );
endinterface

// File: rtl/sspm_connector_v2.sv
// OCP-to-SSPM connector: latches one core request, holds it until the arbiter grants,
// waits out the read latency and answers DVA, or ERR for illegal/protected commands.
module sspm_connector_v2 #(
    parameter int          DATA_WIDTH   = 32,
    parameter int          ADDR_WIDTH   = 16,
    parameter int          READ_LATENCY = 1,
    parameter int unsigned PROT_LIMIT   = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    sspm_connector_v2_if.slave   bus
);
    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [2:0] CMD_WR    = 3'd1;
    localparam logic [2:0] CMD_RD    = 3'd2;
    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_DVA  = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_GRANT,
        ST_READ_WAIT,
        ST_RESP
    } state_t;

    state_t                  state;
    logic [1:0]              lat_cnt;
    logic                    pending_req;
    logic                    pending_we;
    logic                    pending_re;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_data;
    logic [DATA_WIDTH/8-1:0] lat_be;
    logic [1:0]              resp_code;
    logic [DATA_WIDTH-1:0]   resp_data;

    logic [ADDR_WIDTH-1:0]   addr_trunc;
    logic                    is_wr;
    logic                    prot_hit;

    assign addr_trunc = bus.io_ocp_M_Addr[ADDR_WIDTH-1:0];
    assign is_wr      = (bus.io_ocp_M_Cmd == CMD_WR);
    // Protection is judged on the address the arbiter would actually see.
    assign prot_hit   = is_wr && !bus.io_superMode && (32'(addr_trunc) < PROT_LIMIT);

    generate
        if (ADDR_WIDTH < 32) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^bus.io_ocp_M_Addr[31:ADDR_WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            lat_cnt     <= '0;
            pending_req <= 1'b0;
            pending_we  <= 1'b0;
            pending_re  <= 1'b0;
            lat_addr    <= '0;
            lat_data    <= '0;
            lat_be      <= '0;
            resp_code   <= RESP_NULL;
            resp_data   <= '0;
        end else begin
            // Response fields are single-cycle pulses unless set below.
            resp_code <= RESP_NULL;
            resp_data <= '0;
            case (state)
                ST_IDLE: begin
                    if (bus.io_ocp_M_Cmd == CMD_WR || bus.io_ocp_M_Cmd == CMD_RD) begin
                        lat_addr <= addr_trunc;
                        lat_data <= bus.io_ocp_M_Data;
                        lat_be   <= is_wr ? bus.io_ocp_M_ByteEn : '0;
                        if (prot_hit) begin
                            resp_code <= RESP_ERR;
                            state     <= ST_RESP;
                        end else begin
                            pending_req <= 1'b1;
                            pending_we  <= is_wr;
                            pending_re  <= !is_wr;
                            state       <= ST_WAIT_GRANT;
                        end
                    end else if (bus.io_ocp_M_Cmd != CMD_IDLE) begin
                        resp_code <= RESP_ERR;
                        state     <= ST_RESP;
                    end
                end
                ST_WAIT_GRANT: begin
                    if (bus.io_connectorSignals_select) begin
                        pending_req <= 1'b0;
                        pending_we  <= 1'b0;
                        pending_re  <= 1'b0;
                        if (pending_we) begin
                            resp_code <= RESP_DVA;
                            state     <= ST_RESP;
                        end else begin
                            lat_cnt <= 2'(READ_LATENCY - 1);
                            state   <= ST_READ_WAIT;
                        end
                    end
                end
                ST_READ_WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        resp_code <= RESP_DVA;
                        resp_data <= bus.io_connectorSignals_data_in;
                        state     <= ST_RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.io_ocp_S_Resp                = resp_code;
    assign bus.io_ocp_S_Data                = resp_data;
    assign bus.io_connectorSignals_req      = pending_req;
    assign bus.io_connectorSignals_we       = pending_we;
    assign bus.io_connectorSignals_re       = pending_re;
    assign bus.io_connectorSignals_addr     = lat_addr;
    assign bus.io_connectorSignals_data_out = lat_data;
    assign bus.io_connectorSignals_byteEn   = lat_be;
endmodule

// File: tb/tb_sspm_connector_v2.sv
// Bench for sspm_connector_v2: vector table plus hand-written sequences for
// command-while-busy, held grant, and reset mid-transaction; responses go through a scoreboard.
module tb_sspm_connector_v2;
    localparam int          DW = 32;
    localparam int          AW = 16;
    localparam int          RL = 3;
    localparam int unsigned PL = 256;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sspm_connector_v2_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sspm_connector_v2 #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(RL), .PROT_LIMIT(PL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    typedef struct {
        logic [2:0]  cmd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        sup;
        int          grant;
        logic [31:0] rdata;
        logic [1:0]  eresp;
        logic [31:0] edata;
        logic        ereq;
        logic [15:0] eaddr;
        int          elat;
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t sbq[$];
    vec_t vecs[10];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [1:0] r, input logic [31:0] d);
        exp_t e;
        e.resp = r;
        e.data = d;
        sbq.push_back(e);
    endtask

    // Scoreboard: every non-NULL response is matched against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset && bus.io_ocp_S_Resp != 2'd0) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got resp %0d want none", bus.io_ocp_S_Resp);
            end else begin
                e = sbq.pop_front();
                chk("sb_resp", 32'(bus.io_ocp_S_Resp), 32'(e.resp));
                chk("sb_data", bus.io_ocp_S_Data, e.data);
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int   rc;
        int   nresp;
        logic req_ok;
        @(posedge clk); #1;
        bus.io_ocp_M_Cmd    = v.cmd;
        bus.io_ocp_M_Addr   = v.addr;
        bus.io_ocp_M_Data   = v.data;
        bus.io_ocp_M_ByteEn = v.be;
        bus.io_superMode    = v.sup;
        bus.io_connectorSignals_select = 1'b0;
        push_exp(v.eresp, v.edata);
        rc = -1;
        nresp = 0;
        req_ok = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk($sformatf("v%0d_req", idx), 32'(bus.io_connectorSignals_req), 32'(v.ereq));
                if (v.ereq) begin
                    chk($sformatf("v%0d_addr", idx), 32'(bus.io_connectorSignals_addr), 32'(v.eaddr));
                    chk($sformatf("v%0d_we", idx), 32'(bus.io_connectorSignals_we), 32'(v.cmd == 3'd1));
                    chk($sformatf("v%0d_re", idx), 32'(bus.io_connectorSignals_re), 32'(v.cmd == 3'd2));
                    chk($sformatf("v%0d_be", idx), 32'(bus.io_connectorSignals_byteEn),
                        (v.cmd == 3'd1) ? 32'(v.be) : 32'd0);
                    if (v.cmd == 3'd1)
                        chk($sformatf("v%0d_dout", idx), bus.io_connectorSignals_data_out, v.data);
                end
            end
            if (v.ereq && k >= 1 && k <= v.grant && !bus.io_connectorSignals_req) req_ok = 1'b0;
            if (v.ereq && k == v.grant + 1 && bus.io_connectorSignals_req) req_ok = 1'b0;
            if (!v.ereq && bus.io_connectorSignals_req) req_ok = 1'b0;
            if (bus.io_ocp_S_Resp != 2'd0) begin
                nresp++;
                if (rc < 0) rc = k;
            end
            if (rc >= 0 && k >= rc + 2) break;
            @(posedge clk); #1;
            bus.io_ocp_M_Cmd = 3'd0;
            bus.io_connectorSignals_select = (k + 1 == v.grant);
            bus.io_connectorSignals_data_in = (k + 1 == v.grant + RL) ? v.rdata : $urandom;
        end
        chk($sformatf("v%0d_req_window", idx), 32'(req_ok), 32'd1);
        chk($sformatf("v%0d_resp_cycle", idx), rc, v.elat);
        chk($sformatf("v%0d_resp_count", idx), nresp, 32'd1);
    endtask

    initial begin
        int   mask;
        vec_t fresh;
        bus.io_superMode = 1'b0;
        bus.io_ocp_M_Cmd = 3'd0;
        bus.io_ocp_M_Addr = '0;
        bus.io_ocp_M_Data = '0;
        bus.io_ocp_M_ByteEn = '0;
        bus.io_connectorSignals_select = 1'b0;
        bus.io_connectorSignals_data_in = '0;

        //          cmd   addr           data           be    sup grant rdata          eresp edata          ereq eaddr     elat
        vecs[0] = '{3'd1, 32'h0000_0010, 32'hDEADBEEF, 4'hF, 1'b1, 1, 32'h0,         2'd1, 32'h0,         1'b1, 16'h0010, 2};
        vecs[1] = '{3'd2, 32'h0000_0400, 32'h0,        4'hF, 1'b1, 5, 32'h12345678,  2'd1, 32'h12345678,  1'b1, 16'h0400, 9};
        vecs[2] = '{3'd1, 32'h0000_0080, 32'hCAFE0001, 4'hF, 1'b0, 0, 32'h0,         2'd3, 32'h0,         1'b0, 16'h0,    1};
        vecs[3] = '{3'd1, 32'h0000_0100, 32'hCAFE0002, 4'h3, 1'b0, 2, 32'h0,         2'd1, 32'h0,         1'b1, 16'h0100, 3};
        vecs[4] = '{3'd5, 32'h0000_0044, 32'h0,        4'hF, 1'b1, 0, 32'h0,         2'd3, 32'h0,         1'b0, 16'h0,    1};
        vecs[5] = '{3'd2, 32'h0001_0020, 32'h0,        4'hF, 1'b0, 1, 32'hA5A55A5A,  2'd1, 32'hA5A55A5A,  1'b1, 16'h0020, 5};
        vecs[6] = '{3'd1, 32'h0001_00FF, 32'h1,        4'hF, 1'b0, 0, 32'h0,         2'd3, 32'h0,         1'b0, 16'h0,    1};
        vecs[7] = '{3'd1, 32'h0000_0000, 32'h89ABCDEF, 4'h5, 1'b1, 3, 32'h0,         2'd1, 32'h0,         1'b1, 16'h0000, 4};
        vecs[8] = '{3'd7, 32'h0000_0000, 32'h0,        4'h0, 1'b1, 0, 32'h0,         2'd3, 32'h0,         1'b0, 16'h0,    1};
        vecs[9] = '{3'd3, 32'h0000_0200, 32'h0,        4'h0, 1'b1, 0, 32'h0,         2'd3, 32'h0,         1'b0, 16'h0,    1};

        #12;
        chk("rst_resp", 32'(bus.io_ocp_S_Resp), 32'd0);
        chk("rst_req", 32'(bus.io_connectorSignals_req), 32'd0);
        chk("rst_addr", 32'(bus.io_connectorSignals_addr), 32'd0);
        chk("rst_dout", bus.io_connectorSignals_data_out, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Command issued while waiting for grant must not disturb the latched read.
        @(posedge clk); #1;
        bus.io_ocp_M_Cmd = 3'd2;
        bus.io_ocp_M_Addr = 32'h300;
        bus.io_superMode = 1'b1;
        push_exp(2'd1, 32'h0BADF00D);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            bus.io_ocp_M_Cmd = (k <= 3) ? 3'd1 : 3'd0;
            bus.io_ocp_M_Addr = 32'h500;
            bus.io_connectorSignals_select = (k == 4);
            bus.io_connectorSignals_data_in = (k == 7) ? 32'h0BADF00D : $urandom;
            @(negedge clk);
            if (k == 3) begin
                chk("busy_addr", 32'(bus.io_connectorSignals_addr), 32'h300);
                chk("busy_re", 32'(bus.io_connectorSignals_re), 32'd1);
                chk("busy_we", 32'(bus.io_connectorSignals_we), 32'd0);
            end
            if (k == 8) chk("busy_dva", 32'(bus.io_ocp_S_Resp), 32'd1);
        end

        // select held high across two back-to-back writes.
        @(posedge clk); #1;
        bus.io_connectorSignals_select = 1'b1;
        bus.io_ocp_M_Cmd = 3'd1;
        bus.io_ocp_M_Addr = 32'h200;
        bus.io_ocp_M_Data = 32'h11111111;
        bus.io_ocp_M_ByteEn = 4'hF;
        push_exp(2'd1, 32'h0);
        mask = 0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            bus.io_ocp_M_Cmd = (k == 3) ? 3'd1 : 3'd0;
            bus.io_ocp_M_Data = 32'h22222222;
            if (k == 3) push_exp(2'd1, 32'h0);
            bus.io_connectorSignals_select = (k < 10);
            @(negedge clk);
            if (bus.io_ocp_S_Resp != 2'd0) mask |= (1 << k);
            if (k == 4) chk("hold_dout2", bus.io_connectorSignals_data_out, 32'h22222222);
        end
        chk("hold_resp_cycles", mask, 32'h24);

        // Reset while waiting for grant: req drops at once.
        @(posedge clk); #1;
        bus.io_ocp_M_Cmd = 3'd2;
        bus.io_ocp_M_Addr = 32'h40;
        @(posedge clk); #1;
        bus.io_ocp_M_Cmd = 3'd0;
        #2;
        chk("rwg_req_before", 32'(bus.io_connectorSignals_req), 32'd1);
        reset = 1'b0;
        #1;
        chk("rwg_req", 32'(bus.io_connectorSignals_req), 32'd0);
        chk("rwg_re", 32'(bus.io_connectorSignals_re), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Reset during READ_WAIT: the pending read is lost, no response appears.
        @(posedge clk); #1;
        bus.io_ocp_M_Cmd = 3'd2;
        bus.io_ocp_M_Addr = 32'h44;
        @(posedge clk); #1;
        bus.io_ocp_M_Cmd = 3'd0;
        bus.io_connectorSignals_select = 1'b1;
        @(posedge clk); #1;
        bus.io_connectorSignals_select = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("rrw_req", 32'(bus.io_connectorSignals_req), 32'd0);
        chk("rrw_re", 32'(bus.io_connectorSignals_re), 32'd0);
        chk("rrw_resp", 32'(bus.io_ocp_S_Resp), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        fresh = '{3'd2, 32'h0000_0600, 32'h0, 4'hF, 1'b0, 2, 32'h5EED5EED, 2'd1, 32'h5EED5EED, 1'b1, 16'h0600, 6};
        run_vec(fresh, 10);

        repeat (3) @(negedge clk);
        chk("sb_empty", sbq.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
